// File: rtl/pic_timer_pkg.sv
// Shared constants for the PIC-style general timer: register offsets and
// CON/INTC field positions.
package pic_timer_pkg;

    localparam logic [8:0] OFS_TMRL = 9'd0;
    localparam logic [8:0] OFS_TMRH = 9'd1;
    localparam logic [8:0] OFS_CON  = 9'd2;
    localparam logic [8:0] OFS_PRL  = 9'd3;
    localparam logic [8:0] OFS_PRH  = 9'd4;
    localparam logic [8:0] OFS_INTC = 9'd5;

    localparam int unsigned CON_ON   = 7;
    localparam int unsigned CON_CS   = 6;
    localparam int unsigned CON_SE   = 5;
    localparam int unsigned CON_MODE = 4;
    localparam int unsigned CON_PSA  = 3;
    localparam int unsigned CON_PS_L = 0;

    localparam int unsigned INTC_IE     = 7;
    localparam int unsigned INTC_IF     = 6;
    localparam int unsigned INTC_GE     = 5;
    localparam int unsigned INTC_GPOL   = 4;
    localparam int unsigned INTC_POST_L = 0;

    localparam logic MODE_FREE   = 1'b0;
    localparam logic MODE_PERIOD = 1'b1;

endpackage

// File: rtl/pic_tmr_clkgen.sv
// Count-event generator: source select, edge detect, 2^k prescaler and gate.
// Produces a single-cycle inc pulse for the timer core.
module pic_tmr_clkgen #(
    parameter int unsigned PS_WIDTH = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       sync,
    input  logic       tcki,
    input  logic       tgate,
    input  logic       on,
    input  logic       cs,
    input  logic       se,
    input  logic       psa,
    input  logic [2:0] ps,
    input  logic       ge,
    input  logic       gpol,
    input  logic       clr,
    output logic       inc
);

    logic                src;
    logic                src_edge;
    logic                prev_q;
    logic [PS_WIDTH-1:0] presc_q, presc_d;
    logic                presc_rise;
    logic                clk_in_edge;
    logic                run;
    int unsigned         sel;

    always_comb begin
        src      = cs ? (tcki ^ se) : sync;
        src_edge = ~prev_q & src;

        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (on && src_edge) begin
            presc_d = presc_q + PS_WIDTH'(1);
        end

        sel = 32'(ps);
        if (sel >= PS_WIDTH) begin
            sel = PS_WIDTH - 1;
        end

        // Selected prescaler bit going 0->1 on this update is the divided edge.
        presc_rise = 1'b0;
        for (int i = 0; i < int'(PS_WIDTH); i++) begin
            if (32'(i) == sel) begin
                presc_rise = ~presc_q[i] & presc_d[i];
            end
        end

        clk_in_edge = psa ? src_edge : presc_rise;
        run         = on & (~ge | ~(tgate ^ gpol));
        inc         = run & clk_in_edge;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            prev_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            prev_q  <= src;
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pic_timer_n.sv
// PIC-style WIDTH-bit timer on the 9-bit register bus: period/free-run compare,
// 1:1..1:16 postscaler, interrupt flag and enable.
module pic_timer_n
    import pic_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PS_WIDTH = 8,
    parameter logic [8:0]  BASE     = 9'h00E
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Sync,
    input  logic [8:0]       Address,
    input  logic [7:0]       Data,
    input  logic             Latch,
    input  logic             TCKI,
    input  logic             TGATE,
    output logic [WIDTH-1:0] TMR,
    output logic [WIDTH-1:0] PR,
    output logic [7:0]       CON,
    output logic [7:0]       INTC,
    output logic             Irq,
    output logic             Tick
);

    logic [WIDTH-1:0] tmr_q, tmr_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [7:0]       hbuf_q, hbuf_d;
    logic [7:0]       con_q, con_d;
    logic [7:0]       intc_q, intc_d;
    logic [3:0]       post_q, post_d;
    logic             tick_q, tick_d;
    logic             irq_q;
    logic [15:0]      pr_ext;
    logic             terminal;
    logic             inc;
    logic             wr_tmrl, wr_tmrh, wr_con, wr_prl, wr_prh, wr_intc;

    assign wr_tmrl = Latch && (Address == BASE + OFS_TMRL);
    assign wr_tmrh = Latch && (Address == BASE + OFS_TMRH);
    assign wr_con  = Latch && (Address == BASE + OFS_CON);
    assign wr_prl  = Latch && (Address == BASE + OFS_PRL);
    assign wr_prh  = Latch && (Address == BASE + OFS_PRH);
    assign wr_intc = Latch && (Address == BASE + OFS_INTC);

    pic_tmr_clkgen #(
        .PS_WIDTH (PS_WIDTH)
    ) u_clkgen (
        .Clk    (Clk),
        .nReset (nReset),
        .sync   (Sync),
        .tcki   (TCKI),
        .tgate  (TGATE),
        .on     (con_q[CON_ON]),
        .cs     (con_q[CON_CS]),
        .se     (con_q[CON_SE]),
        .psa    (con_q[CON_PSA]),
        .ps     (con_q[CON_PS_L +: 3]),
        .ge     (intc_q[INTC_GE]),
        .gpol   (intc_q[INTC_GPOL]),
        .clr    (wr_tmrl),
        .inc    (inc)
    );

    always_comb begin
        tmr_d  = tmr_q;
        pr_d   = pr_q;
        hbuf_d = hbuf_q;
        con_d  = con_q;
        intc_d = intc_q;
        post_d = post_q;
        tick_d = 1'b0;
        pr_ext = 16'(pr_q);

        terminal = (con_q[CON_MODE] == MODE_PERIOD) ? (tmr_q == pr_q) : (tmr_q == '1);

        if (wr_tmrl) begin
            // Truncation keeps only Data when WIDTH is 8.
            tmr_d  = WIDTH'({hbuf_q, Data});
            post_d = '0;
        end else if (inc) begin
            if (terminal) begin
                tmr_d = '0;
                if (post_q == intc_q[INTC_POST_L +: 4]) begin
                    post_d          = '0;
                    intc_d[INTC_IF] = 1'b1;
                    tick_d          = 1'b1;
                end else begin
                    post_d = post_q + 4'd1;
                end
            end else begin
                tmr_d = tmr_q + WIDTH'(1);
            end
        end

        if (wr_tmrh) hbuf_d = Data;
        if (wr_con)  con_d  = Data;
        if (wr_prl)  pr_ext[7:0]  = Data;
        if (wr_prh)  pr_ext[15:8] = Data;
        pr_d = WIDTH'(pr_ext);
        // Software write to INTC overrides a same-cycle hardware IF set.
        if (wr_intc) intc_d = Data;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            tmr_q  <= '0;
            pr_q   <= '1;
            hbuf_q <= '0;
            con_q  <= '0;
            intc_q <= '0;
            post_q <= '0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            pr_q   <= pr_d;
            hbuf_q <= hbuf_d;
            con_q  <= con_d;
            intc_q <= intc_d;
            post_q <= post_d;
            tick_q <= tick_d;
            irq_q  <= intc_q[INTC_IE] & intc_q[INTC_IF];
        end
    end

    assign TMR  = tmr_q;
    assign PR   = pr_q;
    assign CON  = con_q;
    assign INTC = intc_q;
    assign Irq  = irq_q;
    assign Tick = tick_q;

endmodule
